// File: rtl/ram_alu_pkg.sv
// Shared constants for the accumulator CPU datapath: ALU select codes and ISA opcodes.
package ram_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_NOT = 4'b0101;

  // Instruction opcodes decoded by the CPU sequencer.
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_BACK  = 4'h8;
  localparam logic [3:0] OP_SKIP  = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;
  localparam logic [3:0] OP_CLEAR = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hE;
  localparam logic [3:0] OP_NOT   = 4'hF;

endpackage

// File: rtl/ram_alu_datapath_alu_core.sv
// Combinational ALU with zero/negative flags. SUB/AND/OR/NOT exist only when
// ALU_EXT_OPS_EN is defined; otherwise those codes fall through to 0.
module alu_core
  import ram_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [3:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  alu_zero,
  output logic                  alu_neg
);

  always_comb begin
    alu_out = '0;
    case (alu_sel)
      ALU_ADD: alu_out = alu_a + alu_b;
`ifdef ALU_EXT_OPS_EN
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_NOT: alu_out = ~alu_a;
`endif
      default: alu_out = '0;
    endcase
  end

  assign alu_zero = (alu_out == '0);
  assign alu_neg  = alu_out[DATA_WIDTH-1];

endmodule

// File: rtl/ram_alu_datapath.sv
// Single-port synchronous RAM on a shared tri-state bus plus the combinational ALU.
// Optional ALU operations are enabled by defining ALU_EXT_OPS_EN.
module ram_alu_datapath
  import ram_alu_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs_input,
  input  logic                  we,
  input  logic                  oe,
  input  logic [3:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  alu_zero,
  output logic                  alu_neg
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_reg;
  logic                  drive_en;

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (cs_input && we) mem[addr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rd_reg <= '0;
    else if (cs_input && !we) rd_reg <= mem[addr];
  end

  // we=1 blocks the driver even when oe=1, so a write can never contend.
  assign drive_en = !rst && cs_input && oe && !we;
  assign data     = drive_en ? rd_reg : {DATA_WIDTH{1'bz}};

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .alu_sel  (alu_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg)
  );

endmodule

// File: tb/tb_ram_alu_datapath.sv
// Directed bench for ram_alu_datapath: RAM write/read, bus release, reset mid-read, ALU ops.
// The bus has a pull-up, so a released bus reads as all ones.
module tb_ram_alu_datapath;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam logic [DW-1:0] BUS_IDLE = 16'hFFFF;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  tri1  [DW-1:0] data;
  logic          cs_input;
  logic          we;
  logic          oe;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_out;
  logic          alu_zero;
  logic          alu_neg;

  logic          drv_en;
  logic [DW-1:0] drv_data;

  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];

  assign data = drv_en ? drv_data : {DW{1'bz}};

  ram_alu_datapath #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data),
    .cs_input (cs_input),
    .we       (we),
    .oe       (oe),
    .alu_sel  (alu_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cs_input = 1'b1; we = 1'b1; oe = 1'b0; addr = a;
    drv_en = 1'b1; drv_data = d;
    @(negedge clk);
    cs_input = 1'b0; we = 1'b0; drv_en = 1'b0;
  endtask

  // Leaves cs/oe asserted so the caller can probe the bus afterwards.
  task automatic read_word(input string tag, input logic [AW-1:0] a);
    logic [DW-1:0] exp;
    @(negedge clk);
    cs_input = 1'b1; we = 1'b0; oe = 1'b1; addr = a; drv_en = 1'b0;
    @(negedge clk);
    #1;
    exp = exp_q.pop_front();
    chk(tag, data, exp);
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] sel, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] exp_out,
                         input logic exp_zero, input logic exp_neg);
    alu_sel = sel; alu_a = a; alu_b = b;
    #1;
    chk({tag, "_out"}, alu_out, exp_out);
    chk({tag, "_zero"}, {15'd0, alu_zero}, {15'd0, exp_zero});
    chk({tag, "_neg"}, {15'd0, alu_neg}, {15'd0, exp_neg});
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; cs_input = 1'b0; we = 1'b0; oe = 1'b0; addr = '0;
    drv_en = 1'b0; drv_data = '0;
    alu_sel = 4'd0; alu_a = '0; alu_b = '0;

    repeat (2) @(negedge clk);
    chk("reset_bus_z", data, BUS_IDLE);
    rst = 1'b0;
    cs_input = 1'b1; oe = 1'b1; we = 1'b0;
    #1;
    chk("reset_rd_reg_zero", data, 16'h0000);
    cs_input = 1'b0; oe = 1'b0;

    // basic write then read
    write_word(15'h100, 16'h110C);
    exp_q.push_back(16'h110C);
    read_word("rd_110c", 15'h100);

    // bus release
    oe = 1'b0; #1;
    chk("oe0_release", data, BUS_IDLE);
    oe = 1'b1; #1;
    chk("oe1_drive", data, 16'h110C);
    cs_input = 1'b0; #1;
    chk("cs0_release", data, BUS_IDLE);

    @(negedge clk);
    cs_input = 1'b1; we = 1'b1; oe = 1'b1; addr = 15'h200; drv_en = 1'b0;
    #1;
    chk("we_oe_release", data, BUS_IDLE);
    drv_en = 1'b1; drv_data = 16'hBEEF;
    #1;
    chk("we_master_drive", data, 16'hBEEF);
    @(negedge clk);
    cs_input = 1'b0; we = 1'b0; oe = 1'b0; drv_en = 1'b0;

    exp_q.push_back(16'hBEEF);
    read_word("rd_beef", 15'h200);
    exp_q.push_back(16'h110C);
    read_word("rd_110c_kept", 15'h100);

    // reset in the middle of a read
    cs_input = 1'b0; oe = 1'b0;
    write_word(15'h10D, 16'h0023);
    @(negedge clk);
    cs_input = 1'b1; we = 1'b0; oe = 1'b1; addr = 15'h10D;
    @(posedge clk); #2;
    chk("rd_10d_before_rst", data, 16'h0023);
    rst = 1'b1; #1;
    chk("rst_bus_z", data, BUS_IDLE);
    rst = 1'b0; #1;
    chk("rst_rd_reg_cleared", data, 16'h0000);
    @(posedge clk); #2;
    chk("reread_10d", data, 16'h0023);
    @(negedge clk);
    cs_input = 1'b0; oe = 1'b0;

    // ALU
    alu_chk("add_7_5",      4'b0001, 16'h0007, 16'h0005, 16'h000C, 1'b0, 1'b0);
    alu_chk("add_wrap",     4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    alu_chk("add_neg",      4'b0001, 16'h8000, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
    alu_chk("sel_0000",     4'b0000, 16'h1234, 16'h4321, 16'h0000, 1'b1, 1'b0);
    alu_chk("sel_0111",     4'b0111, 16'h0F0F, 16'h00FF, 16'h0000, 1'b1, 1'b0);
`ifdef ALU_EXT_OPS_EN
    alu_chk("sub_5_7",      4'b0010, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1);
    alu_chk("and",          4'b0011, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0);
    alu_chk("or",           4'b0100, 16'h0F0F, 16'h00FF, 16'h0FFF, 1'b0, 1'b0);
    alu_chk("not",          4'b0101, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b1);
    alu_chk("sel_1111",     4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
`else
    alu_chk("sub_disabled", 4'b0010, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0);
    alu_chk("and_disabled", 4'b0011, 16'h0F0F, 16'h00FF, 16'h0000, 1'b1, 1'b0);
    alu_chk("not_disabled", 4'b0101, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b0);
`endif

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
